// File: rtl/reg_bank_arbiter.sv
// Register bank shared by two requesters over a four-phase req/ack handshake, round-robin arbitrated.
// Latency: grant at edge E, access and ack at E+1, ack drops at E+2; r0_out is a live view of register 0.
module reg_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req0,
  input  logic             we0,
  input  logic [1:0]       addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             ack0,
  input  logic             req1,
  input  logic             we1,
  input  logic [1:0]       addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] r0_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, WAIT} state_t;

  state_t           state, state_nxt;
  logic             grant;
  logic             grant_sel;
  logic             lat_we;
  logic [1:0]       lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] bank [DEPTH];

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_sel = owner;
    case (state)
      IDLE: begin
        // On contention the requester that did not hold the last grant wins.
        if (req0 && req1) begin
          grant     = 1'b1;
          grant_sel = ~owner;
        end else if (req0) begin
          grant     = 1'b1;
          grant_sel = 1'b0;
        end else if (req1) begin
          grant     = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant) state_nxt = ACCESS;
      end
      ACCESS: state_nxt = ACK;
      ACK:    state_nxt = WAIT;
      WAIT:   if (!(owner ? req1 : req0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      owner     <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant) begin
        owner     <= grant_sel;
        lat_we    <= grant_sel ? we1    : we0;
        lat_addr  <= grant_sel ? addr1  : addr0;
        lat_wdata <= grant_sel ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        if (lat_we) bank[lat_addr] <= lat_wdata;
        else        rdata          <= bank[lat_addr];
        if (owner) ack1 <= 1'b1;
        else       ack0 <= 1'b1;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign r0_out = bank[0];

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_reg_bank_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       req0, we0, req1, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, owner;
  logic [7:0] rdata, r0_out;

  int checks = 0;
  int errors = 0;

  reg_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .resetn(resetn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .owner(owner), .r0_out(r0_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit idx, input bit r, input bit we, input logic [1:0] a, input logic [7:0] d);
    if (idx == 1'b0) begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  // One uncontended transaction from IDLE with the requester dropping req on ack.
  task automatic single(input bit idx, input bit we, input logic [1:0] a, input logic [7:0] d, input string tag);
    drive(idx, 1'b1, we, a, d);
    tick();
    chk({tag, "_busy_grant"}, busy, 1);
    chk({tag, "_owner"}, owner, idx);
    chk({tag, "_ack_early"}, {ack1, ack0}, 0);
    tick();
    chk({tag, "_ack"}, {ack1, ack0}, idx ? 2'b10 : 2'b01);
    drive(idx, 1'b0, ~we, ~a, ~d);
    tick();
    chk({tag, "_ack_drop"}, {ack1, ack0}, 0);
    chk({tag, "_busy_wait"}, busy, 1);
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Both requesters raise req together; expects requester 0 served first.
  task automatic contend(input logic [1:0] a, input logic [7:0] d0, input logic [7:0] d1, input string tag);
    drive(0, 1'b1, 1'b1, a, d0);
    drive(1, 1'b1, 1'b1, a, d1);
    tick();
    chk({tag, "_first_owner"}, owner, 0);
    tick();
    chk({tag, "_first_ack"}, {ack1, ack0}, 2'b01);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    chk({tag, "_first_drop"}, {ack1, ack0}, 0);
    tick();
    chk({tag, "_gap_idle"}, busy, 0);
    tick();
    chk({tag, "_second_owner"}, owner, 1);
    chk({tag, "_second_busy"}, busy, 1);
    tick();
    chk({tag, "_second_ack"}, {ack1, ack0}, 2'b10);
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    chk({tag, "_done_idle"}, busy, 0);
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    chk("rst_r0_out", r0_out, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    resetn = 1'b1;

    single(0, 1'b1, 2'd0, 8'hA5, "wr0");
    chk("wr0_r0_out", r0_out, 8'hA5);
    single(0, 1'b0, 2'd0, 8'h00, "rd0");
    chk("rd0_rdata", rdata, 8'hA5);
    single(1, 1'b1, 2'd1, 8'h55, "wr1");
    chk("wr1_rdata_held", rdata, 8'hA5);
    chk("wr1_r0_kept", r0_out, 8'hA5);

    // Contention straight out of reset.
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    contend(2'd3, 8'h11, 8'h22, "ctn1");
    single(1, 1'b0, 2'd3, 8'h00, "rd3");
    chk("rd3_rdata", rdata, 8'h22);
    contend(2'd0, 8'h33, 8'h44, "ctn2");
    chk("ctn2_r0_out", r0_out, 8'h44);

    // Hold: requester 1 keeps req high after its ack while requester 0 waits.
    single(0, 1'b0, 2'd0, 8'h00, "rd0b");
    chk("rd0b_rdata", rdata, 8'h44);
    drive(0, 1'b1, 1'b0, 2'd3, 8'h00);
    drive(1, 1'b1, 1'b1, 2'd0, 8'h66);
    tick();
    chk("hold_owner1", owner, 1);
    tick();
    chk("hold_ack1", {ack1, ack0}, 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_busy", busy, 1);
      chk("hold_no_ack", {ack1, ack0}, 0);
    end
    drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    chk("hold_release_idle", busy, 0);
    chk("hold_owner_kept", owner, 1);
    tick();
    chk("hold_grant0", owner, 0);
    chk("hold_grant0_busy", busy, 1);
    tick();
    chk("hold_ack0", {ack1, ack0}, 2'b01);
    chk("hold_rdata", rdata, 8'h22);
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    chk("hold_done", busy, 0);

    // Reset while in ACCESS of a write to register 2.
    drive(0, 1'b1, 1'b1, 2'd2, 8'h7E);
    tick();
    chk("mid_busy", busy, 1);
    resetn = 1'b0;
    tick();
    chk("mid_no_ack", {ack1, ack0}, 0);
    chk("mid_idle", busy, 0);
    chk("mid_owner", owner, 1);
    chk("mid_r0_out", r0_out, 8'h00);
    resetn = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    single(1, 1'b0, 2'd2, 8'h00, "mid_rd2");
    chk("mid_bank2", rdata, 8'h00);

    // Early drop: req0 high for a single cycle.
    drive(0, 1'b1, 1'b1, 2'd1, 8'h3C);
    tick();
    drive(0, 1'b0, 1'b0, 2'd0, 8'hFF);
    chk("early_busy", busy, 1);
    tick();
    chk("early_ack", {ack1, ack0}, 2'b01);
    tick();
    chk("early_ack_drop", {ack1, ack0}, 0);
    chk("early_wait", busy, 1);
    tick();
    chk("early_idle", busy, 0);
    single(1, 1'b0, 2'd1, 8'h00, "early_rd1");
    chk("early_bank1", rdata, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
